ram_loader: RTL and testbench

Bus initiator that fills the 16×8 program RAM from an external byte stream before the CPU runs. It accepts bytes over a valid/ready handshake, then drives the RAM's address, write-strobe (`ri`), read-strobe (`ro`) and write data to store them at consecutive addresses starting at 0. It sits beside the control unit on the memory port, and the top level muxes its outputs onto the RAM while the CPU is halted. An optional read-back check confirms every stored byte.

---
 rtl/eater_pkg.sv | 25 ++
 rtl/ram_loader.sv | 187 ++++++++++++++++++
 tb/tb_ram_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eater_pkg.sv
// ---------------------------------------------------------------------------
// eater_pkg
// Shared definitions for the program-RAM side of the CPU: RAM geometry and
// the state encoding of the RAM loader.
//   ADDR_W    : RAM address width
//   DATA_W    : RAM word width
//   RAM_DEPTH : number of RAM words
//   loader_state_t : ram_loader FSM states
// ---------------------------------------------------------------------------
package eater_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    VERIFY,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
// Bus initiator that fills the program RAM from a valid/ready byte stream
// while the CPU is halted. Bytes are stored at consecutive addresses from 0.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, len          : begin a load of len bytes (clamped to RAM depth)
//   in_valid, in_data   : incoming stream byte
//   in_ready            : loader takes a byte this cycle (high in ACCEPT)
//   mem_address, ri, ro : RAM address, write strobe, read strobe
//   data_o, data_i      : RAM write data, RAM read data (valid while ro)
//   busy, done, error   : load in progress, completion pulse, sticky
//                         read-back mismatch flag
//
// Optional feature macro: RAM_LOADER_VERIFY_EN
//   Defined     : every written byte is read back and compared; a mismatch
//                 raises error and parks the FSM in ERR at the bad address.
//   Not defined : writes advance directly; ro and error are tied low.
// ---------------------------------------------------------------------------
module ram_loader #(
  parameter int ADDR_W = eater_pkg::ADDR_W,
  parameter int DATA_W = eater_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ri,
  output logic              ro,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy,
  output logic              done,
  output logic              error
);

  import eater_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(1 << ADDR_W);

  loader_state_t     state_q, state_d;
  loader_state_t     adv_state;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [ADDR_W:0]   count_q, count_d, count_inc;
  logic [ADDR_W:0]   len_q, len_d, len_clamped;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ri_q, ri_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef RAM_LOADER_VERIFY_EN
  logic              ro_q, ro_d;
  logic              error_q, error_d;
`else
  logic              unused_data_i;
`endif

  // Requests longer than the RAM are trimmed to a full fill.
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

  // Advance step shared by WRITE (no verify) and VERIFY (on match). The
  // address wraps to 0 only on the last byte of a full fill, and DONE
  // follows immediately, so the wrap never addresses a live write.
  assign count_inc = count_q + 1'b1;
  assign addr_inc  = addr_q + 1'b1;
  assign adv_state = (count_inc == len_q) ? DONE : ACCEPT;

  // Next-state and datapath. Strobes and status are computed from the next
  // state so that they are registered and line up with the state they
  // describe.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    data_d  = data_q;
`ifdef RAM_LOADER_VERIFY_EN
    error_d = error_q;
`endif

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          len_d   = len_clamped;
          addr_d  = '0;
          count_d = '0;
`ifdef RAM_LOADER_VERIFY_EN
          error_d = 1'b0;
`endif
          state_d = (len_clamped == '0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef RAM_LOADER_VERIFY_EN
        state_d = VERIFY;
`else
        count_d = count_inc;
        addr_d  = addr_inc;
        state_d = adv_state;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      VERIFY: begin
        // On mismatch the address is left on the failing word.
        if (data_i != data_q) begin
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          count_d = count_inc;
          addr_d  = addr_inc;
          state_d = adv_state;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ri_d   = (state_d == WRITE);
    done_d = (state_d == DONE);
    busy_d = (state_d == ACCEPT) || (state_d == WRITE) || (state_d == VERIFY);
`ifdef RAM_LOADER_VERIFY_EN
    ro_d   = (state_d == VERIFY);
`endif
  end

  // State and output registers; reset drops the strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ri_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
      ro_q    <= 1'b0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ri_q    <= ri_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RAM_LOADER_VERIFY_EN
      ro_q    <= ro_d;
      error_q <= error_d;
`endif
    end
  end

  assign in_ready    = (state_q == ACCEPT);
  assign mem_address = addr_q;
  assign data_o      = data_q;
  assign ri          = ri_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef RAM_LOADER_VERIFY_EN
  assign ro          = ro_q;
  assign error       = error_q;
`else
  assign ro            = 1'b0;
  assign error         = 1'b0;
  assign unused_data_i = ^data_i;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader
// Self-checking bench for ram_loader. A behavioural RAM sits on the memory
// port; accepted stream bytes are pushed to a scoreboard and popped when the
// loader raises ri. A table of load scenarios is run, followed by hand-written
// sequences for reset mid-load and (with RAM_LOADER_VERIFY_EN) read-back
// mismatch.
// ---------------------------------------------------------------------------
module tb_ram_loader;
  import eater_pkg::*;

`ifdef RAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int PER     = VERIFY ? 3 : 2;
  localparam int WR2DONE = VERIFY ? 2 : 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              ri;
  logic              ro;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] data_i;
  logic              busy;
  logic              done;
  logic              error;

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic              corrupt_en = 1'b0;

  ram_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_address(mem_address),
    .ri         (ri),
    .ro         (ro),
    .data_o     (data_o),
    .data_i     (data_i),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Behavioural program RAM; address 2 can be made to read back as 0xFF.
  always @(posedge clk) begin
    if (ri) ram[mem_address] <= data_o;
  end
  assign data_i = (corrupt_en && mem_address == ADDR_W'(2)) ? 8'hFF : ram[mem_address];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int ln;
    int nbytes;
    int kind;
    bit gaps;
    bit midStart;
    int expWrites;
    int expAddr;
  } vec_t;

  wr_t               sbq[$];
  logic [DATA_W-1:0] exp_ram [RAM_DEPTH];
  int tests = 0;
  int fails = 0;
  int cyc, sent_cnt;
  int busy_cycles, done_pulses, ri_pulses, ro_pulses, ready_cycles;
  int stall_cycles, overlap_cycles, last_ri_cyc, done_cyc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] streamByte(input int kind, input int i);
    case (kind)
      0:       streamByte = (i == 0) ? 8'h53 : (i == 1) ? 8'h4F : 8'h50;
      1:       streamByte = 8'(i);
      2:       streamByte = 8'(i * 37 + 5);
      3:       streamByte = 8'(8'hA0 + i);
      4:       streamByte = 8'(8'hC0 ^ i);
      5:       streamByte = 8'(8'h11 * (i + 1));
      default: streamByte = 8'(8'hA1 + 8'h11 * i);
    endcase
  endfunction

  task automatic clearCounters();
    cyc = 0; sent_cnt = 0;
    busy_cycles = 0; done_pulses = 0; ri_pulses = 0; ro_pulses = 0;
    ready_cycles = 0; stall_cycles = 0; overlap_cycles = 0;
    last_ri_cyc = -1; done_cyc = -1;
    sbq.delete();
  endtask

  // One cycle of monitoring, sampled on the falling edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (busy) busy_cycles++;
    if (in_ready) ready_cycles++;
    if (ro) ro_pulses++;
    if (ri && ro) overlap_cycles++;
    if (done) begin
      done_pulses++;
      done_cyc = cyc;
    end
    if (ri) begin
      ri_pulses++;
      last_ri_cyc = cyc;
      checkOutput("sb_pending", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("sb_addr", 32'(mem_address), 32'(e.addr));
        checkOutput("sb_data", 32'(data_o), 32'(e.data));
      end
    end
  endtask

  // Present the next stream byte; a byte driven while in_ready is high is
  // taken on the coming rising edge, so it is scoreboarded now.
  task automatic driveStep(input int kind, input int nbytes, input bit gaps);
    if (sent_cnt < nbytes) begin
      in_valid = !(gaps && (cyc % 3 == 0));
      in_data  = streamByte(kind, sent_cnt);
    end else begin
      in_valid = 1'b0;
    end
    if (in_ready && !in_valid) stall_cycles++;
    if (in_ready && in_valid) begin
      sbq.push_back('{addr: ADDR_W'(sent_cnt), data: in_data});
      exp_ram[sent_cnt % RAM_DEPTH] = in_data;
      sent_cnt++;
    end
  endtask

  task automatic runLoad(input vec_t v, input string tag);
    int  settle;
    bit  timeout;
    clearCounters();
    settle  = 0;
    timeout = 1'b1;
    start   = 1'b1;
    len     = (ADDR_W+1)'(v.ln);
    for (int k = 0; k < 600; k++) begin
      tick();
      if (v.midStart && cyc < 4) begin
        start = 1'b1;
        len   = (ADDR_W+1)'(1);
      end else begin
        start = 1'b0;
      end
      driveStep(v.kind, v.nbytes, v.gaps);
      if (busy) settle = 0;
      else      settle++;
      if (cyc > 1 && settle >= 3) begin
        timeout = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    runLoad(v, t);
    checkOutput({t, "_done_pulses"}, done_pulses, 1);
    checkOutput({t, "_ri_pulses"}, ri_pulses, v.expWrites);
    checkOutput({t, "_ro_pulses"}, ro_pulses, VERIFY ? v.expWrites : 0);
    checkOutput({t, "_busy_cycles"}, busy_cycles, v.expWrites * PER + stall_cycles);
    checkOutput({t, "_ready_cycles"}, ready_cycles, v.expWrites + stall_cycles);
    checkOutput({t, "_final_addr"}, 32'(mem_address), v.expAddr);
    checkOutput({t, "_error"}, 32'(error), 0);
    checkOutput({t, "_ri_ro_overlap"}, overlap_cycles, 0);
    checkOutput({t, "_sb_leftover"}, sbq.size(), 0);
    if (v.expWrites > 0)
      checkOutput({t, "_done_latency"}, done_cyc - last_ri_cyc, WR2DONE);
    else
      checkOutput({t, "_done_latency"}, done_cyc, 1);
    for (int i = 0; i < v.expWrites; i++)
      checkOutput($sformatf("%s_ram%0d", t, i), 32'(ram[i]), 32'(exp_ram[i]));
  endtask

  initial begin
    vec_t vecs[6];
    logic [DATA_W-1:0] prev1;
    bit reached;

    vecs[0] = '{ln: 3,  nbytes: 3,  kind: 0, gaps: 1'b0, midStart: 1'b0, expWrites: 3,  expAddr: 3};
    vecs[1] = '{ln: 16, nbytes: 16, kind: 1, gaps: 1'b1, midStart: 1'b0, expWrites: 16, expAddr: 0};
    vecs[2] = '{ln: 0,  nbytes: 0,  kind: 1, gaps: 1'b0, midStart: 1'b0, expWrites: 0,  expAddr: 0};
    vecs[3] = '{ln: 20, nbytes: 16, kind: 2, gaps: 1'b0, midStart: 1'b0, expWrites: 16, expAddr: 0};
    vecs[4] = '{ln: 5,  nbytes: 5,  kind: 3, gaps: 1'b1, midStart: 1'b1, expWrites: 5,  expAddr: 5};
    vecs[5] = '{ln: 1,  nbytes: 1,  kind: 4, gaps: 1'b0, midStart: 1'b0, expWrites: 1,  expAddr: 1};

    // Asynchronous reset with no clock edge yet.
    #1;
    checkOutput("reset_outputs", 32'({mem_address, data_o, ri, ro, in_ready, busy, done, error}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Reset asserted during the write of byte 1.
    prev1 = ram[1];
    clearCounters();
    reached = 1'b0;
    start   = 1'b1;
    len     = (ADDR_W+1)'(3);
    for (int k = 0; k < 100; k++) begin
      tick();
      start = 1'b0;
      if (ri_pulses == 2) begin
        reached = 1'b1;
        break;
      end
      driveStep(6, 3, 1'b0);
    end
    checkOutput("rst_reach_write1", 32'(reached), 1);
    checkOutput("rst_write1_addr", 32'(mem_address), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_ri_drop", 32'(ri), 0);
    checkOutput("rst_mid_outputs", 32'({mem_address, data_o, ri, ro, in_ready, busy, done, error}), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clearCounters();
    repeat (4) tick();
    checkOutput("rst_no_done", done_pulses, 0);
    checkOutput("rst_idle_busy", busy_cycles, 0);
    checkOutput("rst_ram0_kept", 32'(ram[0]), 32'h A1);
    checkOutput("rst_ram1_untouched", 32'(ram[1]), 32'(prev1));

`ifdef RAM_LOADER_VERIFY_EN
    // Read-back mismatch at address 2, then recovery with a new start.
    corrupt_en = 1'b1;
    runLoad('{ln: 4, nbytes: 4, kind: 5, gaps: 1'b0, midStart: 1'b0, expWrites: 3, expAddr: 2}, "verr");
    checkOutput("verr_error", 32'(error), 1);
    checkOutput("verr_addr", 32'(mem_address), 2);
    checkOutput("verr_busy", 32'(busy), 0);
    checkOutput("verr_no_done", done_pulses, 0);
    checkOutput("verr_ri_pulses", ri_pulses, 3);
    checkOutput("verr_ro_pulses", ro_pulses, 3);
    corrupt_en = 1'b0;
    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    checkOutput("verr_clear_error", 32'(error), 0);
    checkOutput("verr_clear_done", 32'(done), 1);
    checkOutput("verr_clear_addr", 32'(mem_address), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
